// File: rtl/fetch_pkg.sv
// Shared types and MIPS field positions for the instruction-fetch sequencer
// and its next-PC calculator.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 26;
    localparam int FUNC_MSB = 5;
    localparam int IMM_MSB  = 15;
    localparam int TGT_MSB  = 25;
    localparam int PC_STEP  = 4;

endpackage

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection (jump / taken branch / sequential), shared
// with the single-cycle datapath.
module next_pc_calc
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0]  pc,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic                   jmp,
    input  logic                   pc_src,
    output logic [ADDR_WIDTH-1:0]  next_pc
);

    logic        [ADDR_WIDTH-1:0] pc4;
    logic signed [ADDR_WIDTH-1:0] br_off;
    logic        [ADDR_WIDTH-1:0] jmp_tgt;
    logic                         unused_op;

    assign pc4     = pc + ADDR_WIDTH'(PC_STEP);
    // imm16 is a signed word offset relative to pc+4
    assign br_off  = {{(ADDR_WIDTH-IMM_MSB-3){instr[IMM_MSB]}}, instr[IMM_MSB:0], 2'b00};
    assign jmp_tgt = {pc4[ADDR_WIDTH-1:TGT_MSB+3], instr[TGT_MSB:0], 2'b00};

    assign unused_op = ^instr[INSTR_WIDTH-1:TGT_MSB+1];

    always_comb begin
        next_pc = pc4;
        if (jmp) begin
            next_pc = jmp_tgt;
        end else if (pc_src) begin
            next_pc = pc4 + $unsigned(br_off);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch sequencer: REQ -> WAIT -> HOLD loop feeding decode.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [5:0]             op_code,
    output logic [5:0]             func,
    output logic [ADDR_WIDTH-1:0]  pc_out,
    input  logic                   instr_ack,
    input  logic                   jmp,
`ifdef FETCH_PERF_CNT_EN
    input  logic                   pc_src,
    output logic [31:0]            fetch_count,
    output logic [31:0]            redirect_count
`else
    input  logic                   pc_src
`endif
);

    fetch_state_e           state;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr_r;
    logic                   req_valid_r;
    logic                   instr_valid_r;
    logic [ADDR_WIDTH-1:0]  next_pc;

    next_pc_calc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INSTR_WIDTH(INSTR_WIDTH)
    ) u_next_pc (
        .pc     (pc),
        .instr  (instr_r),
        .jmp    (jmp),
        .pc_src (pc_src),
        .next_pc(next_pc)
    );

    // Handshake outputs are registered alongside the state they decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            instr_r       <= '0;
            req_valid_r   <= 1'b0;
            instr_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state       <= REQ;
                    req_valid_r <= 1'b1;
                end
                REQ: begin
                    if (imem_req_ready) begin
                        state       <= WAIT;
                        req_valid_r <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        instr_r       <= imem_rsp_data;
                        state         <= HOLD;
                        instr_valid_r <= 1'b1;
                    end
                end
                HOLD: begin
                    if (instr_ack) begin
                        pc            <= next_pc;
                        state         <= REQ;
                        instr_valid_r <= 1'b0;
                        req_valid_r   <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    req_valid_r   <= 1'b0;
                    instr_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_valid = req_valid_r;
    assign imem_addr      = pc;
    assign instr_valid    = instr_valid_r;
    assign instr          = instr_r;
    assign op_code        = instr_r[OP_MSB:OP_LSB];
    assign func           = instr_r[FUNC_MSB:0];
    assign pc_out         = pc;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count    <= '0;
            redirect_count <= '0;
        end else begin
            if (state == WAIT && imem_rsp_valid) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (state == HOLD && instr_ack && (jmp || pc_src)) begin
                redirect_count <= redirect_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: expected request addresses are queued when an
// instruction is acked and popped when the DUT's request handshake occurs.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  op_code;
    logic [5:0]  func;
    logic [31:0] pc_out;
    logic        instr_ack;
    logic        jmp;
    logic        pc_src;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] redirect_count;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_count = 0;
    logic [31:0] exp_q[$];
    int hs_cyc_q[$];

    instr_fetch_unit #(
        .ADDR_WIDTH (32),
        .INSTR_WIDTH(32),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .op_code       (op_code),
        .func          (func),
        .pc_out        (pc_out),
        .instr_ack     (instr_ack),
        .jmp           (jmp),
`ifdef FETCH_PERF_CNT_EN
        .pc_src        (pc_src),
        .fetch_count   (fetch_count),
        .redirect_count(redirect_count)
`else
        .pc_src        (pc_src)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // A handshake seen here completes on the following rising edge.
    always @(negedge clk) begin
        if (!rst && imem_req_valid && imem_req_ready) begin
            hs_count++;
            hs_cyc_q.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL req_addr unexpected request addr=%08h", imem_addr);
            end else begin
                logic [31:0] exp_addr;
                exp_addr = exp_q.pop_front();
                if (imem_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL req_addr got=%08h want=%08h", imem_addr, exp_addr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs();
        int start;
        int n;
        start = hs_count;
        n = 0;
        while (hs_count == start && n < 50) begin
            tick();
            n++;
        end
        if (hs_count == start) begin
            checks++;
            errors++;
            $display("FAIL req_handshake timeout got=none want=handshake");
        end
    endtask

    task automatic respond(input logic [31:0] d);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = d;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
    endtask

    task automatic ack_instr(input logic j, input logic b, input logic [31:0] exp_next);
        instr_ack = 1'b1;
        jmp       = j;
        pc_src    = b;
        exp_q.push_back(exp_next);
        tick();
        instr_ack = 1'b0;
        jmp       = 1'b0;
        pc_src    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({imem_req_valid, instr_valid, op_code, func} !== 14'h0) begin
            errors++;
            $display("FAIL reset_ctrl got=%04h want=0000", {imem_req_valid, instr_valid, op_code, func});
        end
        checks++;
        if (imem_addr !== 32'h0 || pc_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc addr=%08h pc_out=%08h want=00000000", imem_addr, pc_out);
        end
        exp_q.push_back(32'h0);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] pcs[3];
        pcs[0] = 32'h0;
        pcs[1] = 32'h4;
        pcs[2] = 32'h8;
        for (int i = 0; i < 3; i++) begin
            wait_hs();
            checks++;
            if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_wait req=%b iv=%b want=0/0", imem_req_valid, instr_valid);
            end
            respond(32'h0000_0020);
            checks++;
            if (instr_valid !== 1'b1 || op_code !== 6'h00 || func !== 6'h20 || pc_out !== pcs[i]) begin
                errors++;
                $display("FAIL basic_hold iv=%b op=%h func=%h pc=%08h want=1/00/20/%08h",
                         instr_valid, op_code, func, pc_out, pcs[i]);
            end
            ack_instr(1'b0, 1'b0, pcs[i] + 32'd4);
        end
        wait_hs();
        respond(32'h0000_0020);
        checks++;
        if (hs_cyc_q.size() < 4) begin
            errors++;
            $display("FAIL basic_latency got=%0d handshakes want=4", hs_cyc_q.size());
        end else if (hs_cyc_q[1] - hs_cyc_q[0] != 3 || hs_cyc_q[2] - hs_cyc_q[1] != 3
                     || hs_cyc_q[3] - hs_cyc_q[2] != 3) begin
            errors++;
            $display("FAIL basic_latency got=%0d,%0d,%0d want=3,3,3", hs_cyc_q[1] - hs_cyc_q[0],
                     hs_cyc_q[2] - hs_cyc_q[1], hs_cyc_q[3] - hs_cyc_q[2]);
        end
        ack_instr(1'b0, 1'b0, 32'h10);
    endtask

    task automatic test_branch();
        wait_hs();
        respond(32'h1000_0003);
        checks++;
        if (op_code !== 6'h04 || pc_out !== 32'h10) begin
            errors++;
            $display("FAIL branch_hold op=%h pc=%08h want=04/00000010", op_code, pc_out);
        end
        ack_instr(1'b0, 1'b1, 32'h20);
        wait_hs();
        respond(32'h1000_FFFB);
        ack_instr(1'b0, 1'b1, 32'h10);
        wait_hs();
        respond(32'h1000_FFFE);
        ack_instr(1'b0, 1'b1, 32'h0C);
    endtask

    task automatic test_jump();
        wait_hs();
        respond(32'h0BFF_FFFF);
        checks++;
        if (op_code !== 6'h02) begin
            errors++;
            $display("FAIL jump_op got=%h want=02", op_code);
        end
        ack_instr(1'b1, 1'b0, 32'h0FFF_FFFC);
        wait_hs();
        respond(32'h0000_0020);
        ack_instr(1'b0, 1'b0, 32'h1000_0000);
        wait_hs();
        respond(32'h0800_0040);
        ack_instr(1'b1, 1'b1, 32'h1000_0100);
    endtask

    task automatic test_stall();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            imem_rsp_valid = (i == 2);
            imem_rsp_data  = 32'hDEAD_BEEF;
            tick();
            checks++;
            if (imem_req_valid !== 1'b1 || imem_addr !== 32'h1000_0100 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_req req=%b addr=%08h iv=%b want=1/10000100/0",
                         imem_req_valid, imem_addr, instr_valid);
            end
        end
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        wait_hs();
        respond(32'h0000_0020);
        checks++;
        if (instr !== 32'h0000_0020 || pc_out !== 32'h1000_0100) begin
            errors++;
            $display("FAIL stall_hold instr=%08h pc=%08h want=00000020/10000100", instr, pc_out);
        end
        ack_instr(1'b0, 1'b0, 32'h1000_0104);
    endtask

    task automatic test_reset_mid_wait();
        wait_hs();
        rst = 1'b1;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_addr !== 32'h0 || instr !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_wait iv=%b req=%b addr=%08h instr=%08h want=0/0/0/0",
                     instr_valid, imem_req_valid, imem_addr, instr);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (fetch_count !== 32'd0 || redirect_count !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset fetch=%0d redirect=%0d want=0/0", fetch_count, redirect_count);
        end
`endif
        tick();
        tick();
        exp_q.push_back(32'h0);
        rst = 1'b0;
    endtask

    task automatic test_hold_and_wrap();
        wait_hs();
        respond(32'h1000_FFFE);
        ack_instr(1'b0, 1'b1, 32'hFFFF_FFFC);
        wait_hs();
        respond(32'h0000_0020);
        for (int i = 0; i < 10; i++) begin
            imem_rsp_valid = (i == 3);
            imem_rsp_data  = 32'hFFFF_FFFF;
            tick();
            checks++;
            if (instr_valid !== 1'b1 || imem_req_valid !== 1'b0 || instr !== 32'h0000_0020
                || func !== 6'h20 || pc_out !== 32'hFFFF_FFFC) begin
                errors++;
                $display("FAIL hold_stable iv=%b req=%b instr=%08h func=%h pc=%08h want=1/0/00000020/20/fffffffc",
                         instr_valid, imem_req_valid, instr, func, pc_out);
            end
        end
        imem_rsp_valid = 1'b0;
        ack_instr(1'b0, 1'b0, 32'h0);
        wait_hs();
        respond(32'h0000_0020);
        checks++;
        if (pc_out !== 32'h0 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_hold pc=%08h iv=%b want=00000000/1", pc_out, instr_valid);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (fetch_count !== 32'd3 || redirect_count !== 32'd1) begin
            errors++;
            $display("FAIL perf_count fetch=%0d redirect=%0d want=3/1", fetch_count, redirect_count);
        end
`endif
        ack_instr(1'b0, 1'b0, 32'h4);
        wait_hs();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending want=0", exp_q.size());
        end
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        instr_ack      = 1'b0;
        jmp            = 1'b0;
        pc_src         = 1'b0;
        test_reset();
        test_basic();
        test_branch();
        test_jump();
        test_stall();
        test_reset_mid_wait();
        test_hold_and_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
